// File: rtl/sram_mem_ctrl_pkg.sv
// Shared types and constants for the memory-stage SRAM controller.
package sram_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } state_t;

  localparam int ADDR_BASE_DEF = 1024;
  localparam int SRAM_DATA_W   = 16;
  localparam int SRAM_ADDR_W   = 18;
  localparam int WORD_ADDR_W   = SRAM_ADDR_W - 1;
  localparam int CNT_W         = 3;

endpackage

// File: rtl/sram_mem_ctrl_wait_counter.sv
// Per-phase wait counter: counts the cycles of one half-word SRAM access.
module sram_wait_counter
  import sram_mem_ctrl_pkg::*;
#(
  parameter int SRAM_WAIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SRAM_WAIT);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign last = (count == LAST_CNT);

endmodule

// File: rtl/sram_mem_ctrl.sv
// Memory-stage controller: each 32-bit load/store becomes two 16-bit SRAM accesses.
// Optional build macro MEM_ALIGN_CHECK_EN enables misaligned-request detection.
module sram_mem_ctrl
  import sram_mem_ctrl_pkg::*;
#(
  parameter int SRAM_WAIT = 1,
  parameter int ADDR_BASE = ADDR_BASE_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   WB_EN_In,
  input  logic                   MEM_R_EN_In,
  input  logic                   MEM_W_EN_In,
  input  logic [3:0]             Dest_In,
  input  logic [31:0]            ALU_Res,
  input  logic [31:0]            Val_Rm,
  output logic                   WB_EN_Out,
  output logic                   MEM_R_EN_Out,
  output logic [3:0]             Dest_Out,
  output logic [31:0]            ALU_Res_Out,
  output logic [31:0]            Mem_Read_Value,
  output logic                   ready,
  output logic                   align_err,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);

  localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(SRAM_WAIT - 1);

  state_t                 state;
  logic                   mem_req;
  logic                   is_wr;
  logic                   cnt_en;
  logic                   cnt_clr;
  logic                   cnt_last;
  logic [CNT_W-1:0]       cnt;
  logic [WORD_ADDR_W-1:0] word_addr;

  assign mem_req   = MEM_R_EN_In | MEM_W_EN_In;
  assign is_wr     = MEM_W_EN_In;
  assign word_addr = WORD_ADDR_W'((ALU_Res - 32'(ADDR_BASE)) >> 2);

  // Freeze starts combinationally in the request cycle and lifts in DONE.
  assign ready        = ~(mem_req & (state != ST_DONE));
  assign WB_EN_Out    = WB_EN_In & ready;
  assign MEM_R_EN_Out = MEM_R_EN_In & ~MEM_W_EN_In;
  assign Dest_Out     = Dest_In;
  assign ALU_Res_Out  = ALU_Res;

  assign cnt_en  = (state == ST_LOW) || (state == ST_HIGH);
  assign cnt_clr = ~cnt_en | cnt_last;

  sram_wait_counter #(
    .SRAM_WAIT (SRAM_WAIT)
  ) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cnt),
    .last  (cnt_last)
  );

`ifdef MEM_ALIGN_CHECK_EN
  logic align_err_q;
  logic misaligned;
  assign misaligned = |ALU_Res[1:0];
  assign align_err  = align_err_q;
`else
  assign align_err = 1'b0;
`endif

  // SRAM strobes are registered from the transition being taken, so they
  // line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      sram_addr      <= '0;
      sram_dq_out    <= '0;
      sram_dq_oe     <= 1'b0;
      sram_we_n      <= 1'b1;
      Mem_Read_Value <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      align_err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (mem_req) begin
`ifdef MEM_ALIGN_CHECK_EN
            if (misaligned) begin
              state       <= ST_DONE;
              align_err_q <= 1'b1;
              if (!is_wr) Mem_Read_Value <= '0;
            end else
`endif
            begin
              state       <= ST_LOW;
              sram_addr   <= {word_addr, 1'b0};
              sram_dq_out <= is_wr ? Val_Rm[15:0] : '0;
              sram_dq_oe  <= is_wr;
              sram_we_n   <= ~is_wr;
            end
          end
        end
        ST_LOW: begin
          if (cnt_last) begin
            state       <= ST_HIGH;
            sram_addr   <= {word_addr, 1'b1};
            sram_dq_out <= is_wr ? Val_Rm[31:16] : '0;
            sram_we_n   <= ~is_wr;
            if (!is_wr) Mem_Read_Value[15:0] <= sram_dq_in;
          end else if (cnt == HOLD_CNT) begin
            sram_we_n <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (cnt_last) begin
            state       <= ST_DONE;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            if (!is_wr) Mem_Read_Value[31:16] <= sram_dq_in;
          end else if (cnt == HOLD_CNT) begin
            sram_we_n <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Directed bench for sram_mem_ctrl with a small SRAM model (SRAM_WAIT = 2).
module tb_sram_mem_ctrl;

  localparam int W    = 2;
  localparam int P    = W + 1;
  localparam int N    = 2 * P + 2;
  localparam int BASE = 1024;

  logic        clk;
  logic        rst;
  logic        WB_EN_In, MEM_R_EN_In, MEM_W_EN_In;
  logic [3:0]  Dest_In;
  logic [31:0] ALU_Res, Val_Rm;
  logic        WB_EN_Out, MEM_R_EN_Out;
  logic [3:0]  Dest_Out;
  logic [31:0] ALU_Res_Out, Mem_Read_Value;
  logic        ready, align_err;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] rd_mem [0:15];
  logic [15:0] wr_mem [0:15];
  logic [15:0] wr_vld;
  int          strobe_cnt;
  logic        wr_clr;
  int          sc_save;

  sram_mem_ctrl #(.SRAM_WAIT(W), .ADDR_BASE(BASE)) u_dut (
    .clk(clk), .rst(rst),
    .WB_EN_In(WB_EN_In), .MEM_R_EN_In(MEM_R_EN_In), .MEM_W_EN_In(MEM_W_EN_In),
    .Dest_In(Dest_In), .ALU_Res(ALU_Res), .Val_Rm(Val_Rm),
    .WB_EN_Out(WB_EN_Out), .MEM_R_EN_Out(MEM_R_EN_Out), .Dest_Out(Dest_Out),
    .ALU_Res_Out(ALU_Res_Out), .Mem_Read_Value(Mem_Read_Value),
    .ready(ready), .align_err(align_err),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign sram_dq_in = rd_mem[sram_addr[3:0]];

  always @(posedge clk) begin
    if (wr_clr) begin
      wr_vld     <= '0;
      strobe_cnt <= 0;
    end else if (!sram_we_n && sram_dq_oe) begin
      wr_mem[sram_addr[3:0]] <= sram_dq_out;
      wr_vld[sram_addr[3:0]] <= 1'b1;
      strobe_cnt             <= strobe_cnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] alu,
                       input logic [31:0] val, input logic wb);
    MEM_R_EN_In = r;
    MEM_W_EN_In = w;
    ALU_Res     = alu;
    Val_Rm      = val;
    WB_EN_In    = wb;
    Dest_In     = 4'h9;
  endtask

  // Runs one memory op from its IDLE cycle through DONE, checking every cycle.
  task automatic op(input string tag, input logic r, input logic w,
                    input logic [31:0] alu, input logic [31:0] val,
                    input logic [31:0] exp_mrv);
    logic [31:0] off;
    logic [16:0] word;
    logic [17:0] e_addr;
    logic [15:0] e_dq;
    logic        e_rdy, e_we_n, e_oe;
    int          k;
    off  = alu - BASE;
    word = off[18:2];
    drive(r, w, alu, val, 1'b1);
    for (int c = 0; c < N; c++) begin
      @(negedge clk);
      e_rdy  = (c == N - 1);
      e_addr = '0;
      e_we_n = 1'b1;
      e_oe   = 1'b0;
      e_dq   = '0;
      if (c >= 1 && c <= P) begin
        k      = c - 1;
        e_addr = {word, 1'b0};
        e_oe   = w;
        e_we_n = !(w && k < W);
        e_dq   = val[15:0];
      end else if (c > P && c <= 2 * P) begin
        k      = c - P - 1;
        e_addr = {word, 1'b1};
        e_oe   = w;
        e_we_n = !(w && k < W);
        e_dq   = val[31:16];
      end
      chk($sformatf("%s_ready_c%0d", tag, c), 32'(ready), 32'(e_rdy));
      chk($sformatf("%s_addr_c%0d", tag, c), 32'(sram_addr), 32'(e_addr));
      chk($sformatf("%s_we_n_c%0d", tag, c), 32'(sram_we_n), 32'(e_we_n));
      chk($sformatf("%s_oe_c%0d", tag, c), 32'(sram_dq_oe), 32'(e_oe));
      chk($sformatf("%s_wb_c%0d", tag, c), 32'(WB_EN_Out), 32'(e_rdy));
      if (e_oe) chk($sformatf("%s_dq_c%0d", tag, c), 32'(sram_dq_out), 32'(e_dq));
      if (c == 0) begin
        chk($sformatf("%s_mem_r_out", tag), 32'(MEM_R_EN_Out), 32'(r & ~w));
        chk($sformatf("%s_alu_out", tag), ALU_Res_Out, alu);
        chk($sformatf("%s_dest_out", tag), 32'(Dest_Out), 32'h9);
      end
      if (c == N - 1 && !w) chk($sformatf("%s_mrv", tag), Mem_Read_Value, exp_mrv);
      cyc();
    end
  endtask

  initial begin
    rst    = 1'b1;
    wr_clr = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 16; i++) rd_mem[i] = 16'h0;
    rd_mem[0]  = 16'h0101;
    rd_mem[1]  = 16'h0202;
    rd_mem[2]  = 16'h5678;
    rd_mem[3]  = 16'h1234;
    rd_mem[14] = 16'h1111;
    rd_mem[15] = 16'h2222;

    // Reset state
    repeat (2) cyc();
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'h1);
    chk("rst_we_n", 32'(sram_we_n), 32'h1);
    chk("rst_oe", 32'(sram_dq_oe), 32'h0);
    chk("rst_addr", 32'(sram_addr), 32'h0);
    chk("rst_dq", 32'(sram_dq_out), 32'h0);
    chk("rst_mrv", Mem_Read_Value, 32'h0);
    chk("rst_align", 32'(align_err), 32'h0);
    cyc();
    rst    = 1'b0;
    wr_clr = 1'b0;

    // Store 0xDEADBEEF at 1024
    op("st", 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("st_mem0", 32'(wr_mem[0]), 32'hBEEF);
    chk("st_mem1", 32'(wr_mem[1]), 32'hDEAD);
    chk("st_strobes", strobe_cnt, 2 * W);
    cyc();

    // Load from 1028
    op("ld", 1'b1, 1'b0, 32'd1028, 32'h0, 32'h12345678);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    // Non-memory op passes straight through
    drive(1'b0, 1'b0, 32'd7, 32'h0, 1'b1);
    sc_save = strobe_cnt;
    @(negedge clk);
    chk("add_ready", 32'(ready), 32'h1);
    chk("add_alu", ALU_Res_Out, 32'd7);
    chk("add_wb", 32'(WB_EN_Out), 32'h1);
    chk("add_addr", 32'(sram_addr), 32'h0);
    chk("add_we_n", 32'(sram_we_n), 32'h1);
    cyc();
    @(negedge clk);
    chk("add_addr2", 32'(sram_addr), 32'h0);
    chk("add_strobes", strobe_cnt, sc_save);
    cyc();

    // Underflowing address wraps to the top SRAM words
    op("wrap", 1'b1, 1'b0, 32'd1020, 32'h0, 32'h22221111);

    // Read and write together behaves as a write
    op("rw", 1'b1, 1'b1, 32'd1040, 32'h55AA33CC, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("rw_mem8", 32'(wr_mem[8]), 32'h33CC);
    chk("rw_mem9", 32'(wr_mem[9]), 32'h55AA);
    chk("rw_mrv_hold", Mem_Read_Value, 32'h22221111);
    cyc();

    // Misaligned load at 1026
`ifdef MEM_ALIGN_CHECK_EN
    sc_save = strobe_cnt;
    drive(1'b1, 1'b0, 32'd1026, 32'h0, 1'b1);
    @(negedge clk);
    chk("mis_ready_c0", 32'(ready), 32'h0);
    chk("mis_addr_c0", 32'(sram_addr), 32'h0);
    cyc();
    @(negedge clk);
    chk("mis_ready_c1", 32'(ready), 32'h1);
    chk("mis_align_c1", 32'(align_err), 32'h1);
    chk("mis_mrv", Mem_Read_Value, 32'h0);
    chk("mis_addr_c1", 32'(sram_addr), 32'h0);
    chk("mis_we_n_c1", 32'(sram_we_n), 32'h1);
    cyc();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("mis_align_sticky", 32'(align_err), 32'h1);
    chk("mis_strobes", strobe_cnt, sc_save);
    cyc();
`else
    op("mis", 1'b1, 1'b0, 32'd1026, 32'h0, 32'h02020101);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("mis_align_off", 32'(align_err), 32'h0);
    cyc();
`endif

    // Reset during cycle 2 of a store to 1032
    drive(1'b0, 1'b1, 32'd1032, 32'hCAFEF00D, 1'b1);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    @(negedge clk);
    chk("rstm_ready", 32'(ready), 32'h0);
    chk("rstm_we_n", 32'(sram_we_n), 32'h1);
    chk("rstm_oe", 32'(sram_dq_oe), 32'h0);
    chk("rstm_addr", 32'(sram_addr), 32'h0);
    chk("rstm_mrv", Mem_Read_Value, 32'h0);
    chk("rstm_align", 32'(align_err), 32'h0);
    chk("rstm_mem4", 32'(wr_mem[4]), 32'hF00D);
    chk("rstm_vld5", 32'(wr_vld[5]), 32'h0);
    cyc();
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("rstm_after_ready", 32'(ready), 32'h1);
    chk("rstm_after_we_n", 32'(sram_we_n), 32'h1);
    cyc();

    // Back-to-back load then store
    op("b2b_ld", 1'b1, 1'b0, 32'd1028, 32'h0, 32'h12345678);
    op("b2b_st", 1'b0, 1'b1, 32'd1036, 32'h0BADF00D, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("b2b_mem6", 32'(wr_mem[6]), 32'hF00D);
    chk("b2b_mem7", 32'(wr_mem[7]), 32'h0BAD);
    chk("b2b_mrv_hold", Mem_Read_Value, 32'h12345678);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_mem_ctrl.md
# sram_mem_ctrl

Memory-stage controller sitting directly downstream of the execute stage. It consumes the execute stage's memory request (`MEM_R_EN`/`MEM_W_EN`, address in `ALU_Res`, store data in `Val_Rm`) and performs each 32-bit load or store as two 16-bit accesses to an external SRAM. While an access is in progress it drives `ready` low so the pipeline freezes. Non-memory instructions pass through with zero added latency.

## Interface
- `SRAM_WAIT`, 1: extra wait cycles per half-word access; legal range 1..7.
- `ADDR_BASE`, 1024: byte address mapped to SRAM word 0.
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `WB_EN_In`, `MEM_R_EN_In`, `MEM_W_EN_In`  in  1 each  control bits from the execute stage.
- `Dest_In`  in  4  destination register.
- `ALU_Res`  in  32  byte address for memory ops; result otherwise.
- `Val_Rm`  in  32  store data.
- `WB_EN_Out`, `MEM_R_EN_Out`  out  1 each  forwarded control bits.
- `Dest_Out`  out  4  forwarded destination.
- `ALU_Res_Out`  out  32  forwarded `ALU_Res`.
- `Mem_Read_Value`  out  32  registered load data.
- `ready`  out  1  0 = freeze pipeline.
- `align_err`  out  1  sticky misalignment flag (see Configuration).
- `sram_addr`  out  18  half-word address.
- `sram_dq_out`  out  16  write data.
- `sram_dq_in`  in  16  read data.
- `sram_dq_oe`  out  1  1 = drive `sram_dq_out`.
- `sram_we_n`  out  1  active-low write strobe.

## Operation
- FSM states:
  - IDLE
  - LOW: half 0, bits [15:0].
  - HIGH: half 1, bits [31:16].
  - DONE
- IDLE → LOW when `MEM_R_EN_In | MEM_W_EN_In`.
- LOW → HIGH and HIGH → DONE each after `SRAM_WAIT+1` cycles, counted by the wait counter.
- DONE → IDLE unconditionally.
- `ready = ~(mem_req & state != DONE)`. This is combinational, so the freeze begins in the request cycle.
- Word address = `(ALU_Res - ADDR_BASE) >> 2`, truncated to 17 bits.
- `sram_addr = {word_addr, half}`, where `half` is 0 in LOW and 1 in HIGH. In IDLE and DONE `sram_addr` is 0.
- Write, both phases:
  - `sram_dq_oe = 1`.
  - `sram_dq_out` = the `Val_Rm` half for that phase.
  - `sram_we_n = 0` for the first `SRAM_WAIT` cycles of the phase and 1 in the phase's last cycle (hold).
- Read:
  - `sram_we_n = 1`, `sram_dq_oe = 0`.
  - `sram_dq_in` is captured into the matching half of `Mem_Read_Value` on the last cycle of each phase.
  - `Mem_Read_Value` holds its value until the next read.
- If both R and W are set, the access is a write and `MEM_R_EN_Out` is forced to 0.
- Pass-through outputs are combinational copies of the inputs.
- `WB_EN_Out` is gated to 0 while `ready = 0`, so the downstream register captures no writeback during a freeze.
- Upstream holds all inputs stable while `ready = 0`. The controller latches nothing except read data.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - `Mem_Read_Value = 0`, `align_err = 0`.
  - `sram_we_n = 1`, `sram_dq_oe = 0`, `sram_addr = 0`, `sram_dq_out = 0`.
- Memory op occupancy is `2*(SRAM_WAIT+1)+2` cycles; 6 at the default.
  - Cycle 0: IDLE, `ready = 0`.
  - Cycles 1–2: LOW.
  - Cycles 3–4: HIGH.
  - Cycle 5: DONE, `ready = 1`. Read data is valid here; the pipeline advances at the end of cycle 5.
- Back-to-back memory ops: the next op's IDLE cycle immediately follows DONE.
- Non-memory op: `ready = 1` in the same cycle; 0 cycles added.
- `rst` asserted mid-access:
  - Next edge: IDLE, `sram_we_n = 1`, `sram_dq_oe = 0`.
  - A partially written word is left as is (no rollback).
- Address wrap: a subtraction underflow (`ALU_Res < ADDR_BASE`) wraps modulo 2^17 words. No error is raised.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A request with `ALU_Res[1:0] != 0` skips LOW/HIGH and goes IDLE → DONE.
  - No SRAM strobe is issued.
  - `Mem_Read_Value` is set to 0 on a misaligned read.
  - `align_err` sets and stays set until `rst`.
- Not defined: `ALU_Res[1:0]` is ignored and `align_err` is tied to 0.

## Structure
- Shared package:
  - FSM state enum (IDLE/LOW/HIGH/DONE).
  - `ADDR_BASE` default.
  - SRAM width constants (16 data, 18 addr).
- One sub-module, `sram_wait_counter`:
  - 3-bit counter with `clr` and `en`.
  - Outputs `last` when count == `SRAM_WAIT`.
  - Same synchronous reset.

## Test plan
- Store `ALU_Res = 1024`, `Val_Rm = 0xDEADBEEF`:
  - `sram_addr` 0 with dq 0xBEEF, then `sram_addr` 1 with dq 0xDEAD.
  - `sram_we_n` low 1 cycle per phase.
  - `ready` low for cycles 0–4, high in cycle 5.
- Load `ALU_Res = 1028`, SRAM model returns 0x5678 at addr 2 and 0x1234 at addr 3:
  - `Mem_Read_Value = 0x12345678` in DONE.
  - `WB_EN_Out` is 0 in cycles 0–4 and 1 in cycle 5.
- ADD, no memory enable, `ALU_Res = 7`: `ready = 1`, `ALU_Res_Out = 7` in the same cycle, no SRAM activity.
- `rst` in cycle 2 of a store: next cycle IDLE, `sram_we_n = 1`, `sram_dq_oe = 0`, `ready = 0` if the request is still present.
- With `MEM_ALIGN_CHECK_EN`, load `ALU_Res = 1026`:
  - No `sram_we_n`/`sram_addr` activity.
  - `ready` high in cycle 1.
  - `align_err = 1` and stays 1 until `rst`.
- Back-to-back load then store with `SRAM_WAIT = 2`: each op takes 8 cycles and the second starts immediately after the first's DONE.
